jio_hub: RTL and testbench

//  Parametrised I/O subsystem between the CPU bus and NDEV peripheral channels; replaces the single-register TTY latch.

---
 rtl/jio_hub.sv | 203 ++++++++++++++++++++
 tb/tb_jio_hub.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jio_hub.sv
// jio_hub: CPU-side I/O hub for NDEV peripheral channels.
// Decodes the CU strobes into address select, data write, data read,
// status read and status clear-on-read.
// Each device has a DEPTH-entry TX FIFO and a one-entry RX holding register.
// The device side uses valid/ready handshakes.
// bus_out feeds a wired-OR CPU bus, so it stays zero unless a read is enabled.
module jio_hub #(
    parameter int WIDTH = 8,
    parameter int NDEV  = 4,
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    reset_n,
    input  logic [WIDTH-1:0]        bus_in,
    output logic [WIDTH-1:0]        bus_out,
    input  logic                    io_s,
    input  logic                    io_e,
    input  logic                    io_da,
    input  logic                    io_io,
    output logic [NDEV*WIDTH-1:0]   tx_data,
    output logic [NDEV-1:0]         tx_valid,
    input  logic [NDEV-1:0]         tx_ready,
    input  logic [NDEV*WIDTH-1:0]   rx_data,
    input  logic [NDEV-1:0]         rx_valid,
    output logic [NDEV-1:0]         rx_ready,
    output logic [7:0]              sel_dev
);

    localparam int IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam logic [8:0]  NDEV_C  = 9'(NDEV);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic              io_s_q_r;
    logic              io_e_q_r;
    logic              rise_s_s;
    logic              fall_e_s;
    logic [7:0]        dev_sel_r;
    logic              inv_s;
    logic [IDXW-1:0]   idx_s;
    logic              addr_op_s;
    logic              wr_op_s;
    logic              wr_any_s;
    logic              rd_clr_s;
    logic              st_clr_s;

    logic [NDEV-1:0]   rx_full_v;
    logic [NDEV-1:0]   ovf_v;
    logic [NDEV-1:0]   tx_full_v;
    logic [NDEV-1:0]   tx_empty_v;
    logic [WIDTH-1:0]  rx_buf_v [NDEV];

    // Edge detection on the CU strobes.
    // The history registers reset high, so a strobe that is already high
    // when reset is released is ignored.
    assign rise_s_s = io_s & ~io_s_q_r;
    assign fall_e_s = ~io_e & io_e_q_r;

    // A selected address outside the channel range marks the selection invalid.
    assign inv_s = ({1'b0, dev_sel_r} >= NDEV_C);
    assign idx_s = dev_sel_r[IDXW-1:0];

    // Operation decode. Writes and clears are suppressed while the selection is invalid.
    assign addr_op_s = rise_s_s & io_da & io_io;
    assign wr_any_s  = rise_s_s & ~io_da & io_io;
    assign wr_op_s   = wr_any_s & ~inv_s;
    assign rd_clr_s  = fall_e_s & ~io_da & ~io_io & ~inv_s;
    assign st_clr_s  = fall_e_s & io_da & ~io_io & ~inv_s;

    assign sel_dev = dev_sel_r;

    // Strobe history registers.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            io_s_q_r <= 1'b1;
            io_e_q_r <= 1'b1;
        end else begin
            io_s_q_r <= io_s;
            io_e_q_r <= io_e;
        end
    end

    // Device-address select register.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            dev_sel_r <= 8'd0;
        end else if (addr_op_s) begin
            dev_sel_r <= bus_in[7:0];
        end else begin
            dev_sel_r <= dev_sel_r;
        end
    end

    for (genvar d = 0; d < NDEV; d++) begin : g_dev
        logic [WIDTH-1:0] mem_r [DEPTH];
        logic [PW-1:0]    wr_ptr_r;
        logic [PW-1:0]    rd_ptr_r;
        logic [PW:0]      cnt_r;
        logic             ovf_r;
        logic             rx_full_r;
        logic [WIDTH-1:0] rx_buf_r;
        logic             sel_s;
        logic             full_s;
        logic             push_s;
        logic             pop_s;

        assign sel_s  = (idx_s == IDXW'(d));
        // Fullness is judged on the pre-edge count, so a same-cycle pop does not make room.
        assign full_s = (cnt_r == DEPTH_C);
        assign push_s = wr_op_s & sel_s & ~full_s;
        assign pop_s  = (cnt_r != '0) & tx_ready[d];

        // TX storage. Its contents are discarded on reset by clearing the pointers.
        always_ff @(posedge CLK) begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus_in;
            end
        end

        // TX FIFO pointers and occupancy count.
        always_ff @(posedge CLK or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                cnt_r    <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   cnt_r <= cnt_r + (PW + 1)'(1);
                    2'b01:   cnt_r <= cnt_r - (PW + 1)'(1);
                    default: cnt_r <= cnt_r;
                endcase
            end
        end

        // Overflow flag.
        // It is set by a write onto a full FIFO and cleared when a status read completes.
        always_ff @(posedge CLK or negedge reset_n) begin
            if (!reset_n) begin
                ovf_r <= 1'b0;
            end else if (wr_op_s && sel_s && full_s) begin
                ovf_r <= 1'b1;
            end else if (st_clr_s && sel_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end

        // RX holding register.
        // It captures a byte whenever it is empty, regardless of the current selection.
        // A completed data read empties it again.
        always_ff @(posedge CLK or negedge reset_n) begin
            if (!reset_n) begin
                rx_full_r <= 1'b0;
                rx_buf_r  <= '0;
            end else if (rx_valid[d] && !rx_full_r) begin
                rx_full_r <= 1'b1;
                rx_buf_r  <= rx_data[d*WIDTH +: WIDTH];
            end else if (rd_clr_s && sel_s) begin
                rx_full_r <= 1'b0;
            end else begin
                rx_full_r <= rx_full_r;
            end
        end

        assign tx_data[d*WIDTH +: WIDTH] = mem_r[rd_ptr_r];
        assign tx_valid[d]   = (cnt_r != '0);
        assign rx_ready[d]   = ~rx_full_r;
        assign rx_full_v[d]  = rx_full_r;
        assign ovf_v[d]      = ovf_r;
        assign tx_full_v[d]  = full_s;
        assign tx_empty_v[d] = (cnt_r == '0);
        assign rx_buf_v[d]   = rx_buf_r;
    end

    // CPU read mux for the wired-OR bus. It drives zero whenever no read is enabled.
    always_comb begin
        bus_out = '0;
        if (io_e && !io_io && !io_da) begin
            if (!inv_s && rx_full_v[idx_s]) begin
                bus_out = rx_buf_v[idx_s];
            end else begin
                bus_out = '0;
            end
        end else if (io_e && !io_io && io_da) begin
            if (inv_s) begin
                bus_out = {{(WIDTH-5){1'b0}}, 5'b10000};
            end else begin
                bus_out = {{(WIDTH-5){1'b0}}, 1'b0, ovf_v[idx_s], rx_full_v[idx_s],
                           tx_full_v[idx_s], tx_empty_v[idx_s]};
            end
        end else begin
            bus_out = '0;
        end
    end

endmodule

// File: tb/tb_jio_hub.sv
// Directed self-checking bench for jio_hub (WIDTH=8, NDEV=4, DEPTH=4).
module tb_jio_hub;

    logic        CLK;
    logic        reset_n;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        io_s;
    logic        io_e;
    logic        io_da;
    logic        io_io;
    logic [31:0] tx_data;
    logic [3:0]  tx_valid;
    logic [3:0]  tx_ready;
    logic [31:0] rx_data;
    logic [3:0]  rx_valid;
    logic [3:0]  rx_ready;
    logic [7:0]  sel_dev;

    int checks   = 0;
    int failures = 0;

    jio_hub #(.WIDTH(8), .NDEV(4), .DEPTH(4)) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .io_s     (io_s),
        .io_e     (io_e),
        .io_da    (io_da),
        .io_io    (io_io),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .sel_dev  (sel_dev)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One set-strobe cycle: da selects address (1) or data (0).
    task automatic cpu_set(input logic da, input logic [7:0] v);
        @(negedge CLK);
        bus_in = v;
        io_da  = da;
        io_io  = 1'b1;
        io_s   = 1'b1;
        @(negedge CLK);
        io_s = 1'b0;
        @(negedge CLK);
    endtask

    // One enable-strobe read: da selects status (1) or data (0).
    task automatic cpu_read(input logic da, output logic [7:0] v);
        @(negedge CLK);
        io_da = da;
        io_io = 1'b0;
        io_e  = 1'b1;
        @(negedge CLK);
        v    = bus_out;
        io_e = 1'b0;
        @(negedge CLK);
    endtask

    logic [7:0] rv;
    logic [7:0] exp_drain [4];

    initial begin
        exp_drain[0] = 8'h11;
        exp_drain[1] = 8'h22;
        exp_drain[2] = 8'h33;
        exp_drain[3] = 8'h44;

        reset_n  = 1'b0;
        bus_in   = 8'h00;
        io_s     = 1'b0;
        io_e     = 1'b0;
        io_da    = 1'b0;
        io_io    = 1'b0;
        tx_ready = 4'h0;
        rx_data  = 32'h0;
        rx_valid = 4'h0;
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        @(negedge CLK);

        // Reset then idle.
        chk("reset_bus_out", 32'(bus_out), 32'h00);
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_rx_ready", 32'(rx_ready), 32'hF);
        chk("reset_sel_dev", 32'(sel_dev), 32'h00);

        // Fill device 2 past capacity with the device not ready.
        cpu_set(1'b1, 8'd2);
        chk("addr2_sel_dev", 32'(sel_dev), 32'd2);
        cpu_set(1'b0, 8'h11);
        cpu_set(1'b0, 8'h22);
        cpu_set(1'b0, 8'h33);
        cpu_set(1'b0, 8'h44);
        cpu_set(1'b0, 8'h55);
        chk("fill_tx_valid", 32'(tx_valid), 32'h4);
        chk("fill_head", 32'(tx_data[23:16]), 32'h11);
        cpu_read(1'b1, rv);
        chk("status_full_ovf", 32'(rv), 32'h0A);
        cpu_read(1'b1, rv);
        chk("status_ovf_cleared", 32'(rv), 32'h02);
        chk("idle_bus_out", 32'(bus_out), 32'h00);

        // Drain device 2 in order.
        tx_ready = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_head_%0d", i), 32'(tx_data[23:16]), 32'(exp_drain[i]));
            @(negedge CLK);
        end
        chk("drain_tx_valid", 32'(tx_valid), 32'h0);
        tx_ready = 4'h0;
        cpu_read(1'b1, rv);
        chk("status_empty", 32'(rv), 32'h01);

        // RX capture on device 1 while device 2 is still selected.
        rx_data[15:8] = 8'h5A;
        rx_valid      = 4'b0010;
        @(negedge CLK);
        chk("rx_ready_captured", 32'(rx_ready), 32'hD);
        rx_valid      = 4'h0;
        rx_data[15:8] = 8'h00;
        cpu_set(1'b1, 8'd1);
        cpu_read(1'b1, rv);
        chk("status_rx_full", 32'(rv), 32'h05);
        cpu_read(1'b0, rv);
        chk("rx_read", 32'(rv), 32'h5A);
        chk("rx_ready_released", 32'(rx_ready), 32'hF);
        cpu_read(1'b0, rv);
        chk("rx_reread", 32'(rv), 32'h00);

        // An out-of-range selection is flagged, and writes to it are dropped.
        cpu_set(1'b1, 8'd7);
        chk("addr7_sel_dev", 32'(sel_dev), 32'd7);
        cpu_read(1'b1, rv);
        chk("status_inv", 32'(rv), 32'h10);
        cpu_set(1'b0, 8'h99);
        chk("inv_write_tx_valid", 32'(tx_valid), 32'h0);
        cpu_read(1'b0, rv);
        chk("inv_data_read", 32'(rv), 32'h00);
        for (int d = 0; d < 4; d++) begin
            cpu_set(1'b1, 8'(d));
            cpu_read(1'b1, rv);
            chk($sformatf("no_ovf_dev%0d", d), 32'(rv), 32'h01);
        end

        // Partial fill of device 0, then a reset that is held across io_s high.
        cpu_set(1'b1, 8'd0);
        cpu_set(1'b0, 8'hA1);
        cpu_set(1'b0, 8'hA2);
        cpu_set(1'b0, 8'hA3);
        chk("dev0_tx_valid", 32'(tx_valid), 32'h1);
        cpu_read(1'b1, rv);
        chk("dev0_status_3", 32'(rv), 32'h00);
        @(negedge CLK);
        bus_in  = 8'hEE;
        io_da   = 1'b0;
        io_io   = 1'b1;
        io_s    = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_tx_valid", 32'(tx_valid), 32'h0);
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        repeat (3) @(negedge CLK);
        chk("held_strobe_tx_valid", 32'(tx_valid), 32'h0);
        io_s = 1'b0;
        @(negedge CLK);
        chk("post_reset_sel_dev", 32'(sel_dev), 32'h00);
        cpu_read(1'b1, rv);
        chk("post_reset_status", 32'(rv), 32'h01);
        chk("post_reset_tx_valid", 32'(tx_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
